rnn_host_sequencer: RTL

- Bus initiator that drives the RNN accelerator's memory-mapped slave port: read, write, addr, data_in, data_out.
- Accepts a stream of high-level commands and turns each into correctly timed bus transactions:
  - parameter/input writes;
  - timestep start followed by a fixed settle wait;
  - dense trigger, status polling and result readback.
- Sits between a command source (soft CPU bridge or ROM walker) and the rnn slave; returns results on a valid/ready output.

---
 rtl/rnn_host_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rnn_host_sequencer.sv
// rnn_host_sequencer: turns WRITE/STEP/DENSE/NOP commands into timed
// bus cycles on the rnn slave port and returns dense results.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   cmd_valid/cmd_ready/op/addr/data    command stream in
//   rnn_read/write/addr/wdata/rdata     slave bus (rdata is combinational)
//   res_valid/res_ready/res_data        dense result out
//   busy, err                           not-idle flag, sticky poll timeout
module rnn_host_sequencer #(
    parameter int STEP_WAIT = 64,
    parameter int POLL_MAX  = 1024,
    parameter int PW        = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rnn_read,
    output logic        rnn_write,
    output logic [31:0] rnn_addr,
    output logic [31:0] rnn_wdata,
    input  logic [31:0] rnn_rdata,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        busy,
    output logic        err
);

    // The wait counter only ever holds STEP_WAIT-1 down to 0.
    localparam int SW = (STEP_WAIT > 1) ? $clog2(STEP_WAIT) : 1;
    localparam logic [SW-1:0] STEP_LOAD =
        SW'((STEP_WAIT > 0) ? (STEP_WAIT - 1) : 0);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_STEP  = 2'd1;
    localparam logic [1:0] OP_DENSE = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_STEP_WR,
        S_STEP_WAIT,
        S_DN_WR,
        S_POLL,
        S_RD,
        S_OUT
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [2:0]    lat_addr;
    logic [31:0]   lat_data;
    logic [SW-1:0] step_cnt;
    logic [PW-1:0] poll_cnt;
    logic          accept;
    logic          status;
    logic          poll_expire;

    // Upper half of the result word carries nothing for this block.
    logic unused_rdata;
    assign unused_rdata = ^rnn_rdata[31:16];

    assign accept      = (state == S_IDLE) && cmd_valid;
    assign status      = rnn_rdata[0];
    assign poll_expire = (state == S_POLL) && !status
                         && (poll_cnt == POLL_LAST);

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_OUT);

    always_comb begin
        state_d   = state;
        rnn_read  = 1'b0;
        rnn_write = 1'b0;
        rnn_addr  = 32'd0;
        rnn_wdata = 32'd0;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    unique case (cmd_op)
                        OP_WRITE: state_d = S_WR;
                        OP_STEP:  state_d = S_STEP_WR;
                        OP_DENSE: state_d = S_DN_WR;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
            S_WR: begin
                rnn_write = 1'b1;
                rnn_addr  = {29'd0, lat_addr};
                rnn_wdata = lat_data;
                state_d   = S_IDLE;
            end
            S_STEP_WR: begin
                rnn_write = 1'b1;
                state_d   = (STEP_WAIT == 0) ? S_IDLE : S_STEP_WAIT;
            end
            S_STEP_WAIT: begin
                if (step_cnt == '0) state_d = S_IDLE;
            end
            S_DN_WR: begin
                rnn_write = 1'b1;
                rnn_addr  = 32'd7;
                state_d   = S_POLL;
            end
            S_POLL: begin
                rnn_read = 1'b1;
                if (status)           state_d = S_RD;
                else if (poll_expire) state_d = S_IDLE;
            end
            S_RD: begin
                rnn_read = 1'b1;
                rnn_addr = 32'd7;
                state_d  = S_OUT;
            end
            S_OUT: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            lat_addr <= 3'd0;
            lat_data <= 32'd0;
            step_cnt <= '0;
            poll_cnt <= '0;
            res_data <= 16'd0;
            err      <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                lat_addr <= cmd_addr;
                lat_data <= cmd_data;
            end
            if (state == S_STEP_WR) begin
                step_cnt <= STEP_LOAD;
            end else if (state == S_STEP_WAIT && step_cnt != '0) begin
                step_cnt <= step_cnt - 1'b1;
            end
            if (state == S_DN_WR) begin
                poll_cnt <= '0;
            end else if (state == S_POLL && !status && !poll_expire) begin
                poll_cnt <= poll_cnt + 1'b1;
            end
            if (poll_expire) err <= 1'b1;
            if (state == S_RD) res_data <= rnn_rdata[15:0];
        end
    end

endmodule
